// File: rtl/alu_result_fifo.sv
// alu_result_fifo
//   Show-ahead synchronous FIFO behind the 10-bit signed ALU. Every valid
//   o_result/o_flag pair from the ALU is captured. The pairs are handed to
//   a consumer over a valid/ready handshake.
//   Pushes that arrive while the FIFO is full are discarded and counted in
//   a saturating drop counter, so lost ALU output is always visible.
//   A sticky OR of all accepted flags is kept until it is cleared.
//
//   Optional build macro: ALU_FIFO_PEAK_EN
//     When this macro is defined, o_peak tracks the high-water mark of o_count.
//     When it is undefined, o_peak is tied to 0 and no register is built.
//
//   Result words are stored as raw bits. The block does no arithmetic on
//   them and does no sign handling.

module alu_result_fifo #(
  parameter int DATA_W = 10,
  parameter int FLAG_W = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_result,
  input  logic [FLAG_W-1:0] i_flag,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_result,
  output logic [FLAG_W-1:0] o_flag,
  input  logic              i_ready,
  output logic [ADDR_W:0]   o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic [FLAG_W-1:0] o_sticky_flag,
  input  logic              i_sticky_clr,
  output logic [7:0]        o_drop_cnt,
  output logic [ADDR_W:0]   o_peak
);

  localparam int ENT_W = DATA_W + FLAG_W;
  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Saturating increment for the drop counter: it holds at 255 and never wraps.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end
    return v + 8'd1;
  endfunction

  // Larger of two occupancy values, used for the high-water mark.
  function automatic logic [ADDR_W:0] max_cnt(input logic [ADDR_W:0] a,
                                               input logic [ADDR_W:0] b);
    return (a > b) ? a : b;
  endfunction

  // Storage. The memory is a data path and is never reset.
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [ENT_W-1:0]  head;

  // Registered control state.
  logic [ADDR_W-1:0] wr_ptr_p0;
  logic [ADDR_W-1:0] rd_ptr_p0;
  logic [ADDR_W:0]   count_p0;
  logic [FLAG_W-1:0] sticky_p0;
  logic [7:0]        drop_p0;

  // Next-state terms.
  logic              push;
  logic              pop;
  logic              drop;
  logic [ADDR_W:0]   count_nxt;
  logic [FLAG_W-1:0] sticky_nxt;

  // Status flags depend on registered occupancy only. There is no
  // combinational path from i_valid or i_ready to these outputs.
  assign o_full  = (count_p0 == FULL_CNT);
  assign o_empty = (count_p0 == '0);
  assign o_ready = ~o_full;
  assign o_valid = ~o_empty;
  assign o_count = count_p0;

  assign push = i_valid & ~o_full;
  assign pop  = i_ready & ~o_empty;
  assign drop = i_valid &  o_full;

  // The head entry is shown ahead of the pop. Its output is forced to zero
  // whenever the FIFO is empty, so stale memory never leaks out.
  assign head     = mem[rd_ptr_p0];
  assign o_result = o_empty ? '0 : head[ENT_W-1:FLAG_W];
  assign o_flag   = o_empty ? '0 : head[FLAG_W-1:0];

  assign o_sticky_flag = sticky_p0;
  assign o_drop_cnt    = drop_p0;

  // Occupancy after this edge. A simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_nxt = count_p0;
    case ({push, pop})
      2'b10:   count_nxt = count_p0 + CNT_ONE;
      2'b01:   count_nxt = count_p0 - CNT_ONE;
      default: count_nxt = count_p0;
    endcase
  end

  // Sticky flags. A clear is applied first, and then the flags of an
  // accepted push are ORed in. Dropped entries never contribute.
  always_comb begin
    sticky_nxt = sticky_p0;
    if (i_sticky_clr) begin
      sticky_nxt = '0;
    end
    if (push) begin
      sticky_nxt = sticky_nxt | i_flag;
    end
  end

  // Capture an accepted ALU result at the write pointer.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr_p0] <= {i_result, i_flag};
    end
  end

  // Pointers, occupancy, sticky flags and drop counter. Reset overrides all.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_p0 <= '0;
      rd_ptr_p0 <= '0;
      count_p0  <= '0;
      sticky_p0 <= '0;
      drop_p0   <= '0;
    end else begin
      if (push) begin
        wr_ptr_p0 <= wr_ptr_p0 + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_p0 <= rd_ptr_p0 + PTR_ONE;
      end
      count_p0  <= count_nxt;
      sticky_p0 <= sticky_nxt;
      if (drop) begin
        drop_p0 <= sat_inc8(drop_p0);
      end
    end
  end

`ifdef ALU_FIFO_PEAK_EN
  logic [ADDR_W:0] peak_p0;

  // High-water mark of occupancy. A clear restarts it from the new occupancy.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      peak_p0 <= '0;
    end else if (i_sticky_clr) begin
      peak_p0 <= count_nxt;
    end else begin
      peak_p0 <= max_cnt(peak_p0, count_nxt);
    end
  end

  assign o_peak = peak_p0;
`else
  assign o_peak = '0;
`endif

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Downstream stage of the 10-bit signed ALU: captures each produced o_result/o_flag pair into a small synchronous FIFO.
- Presents the captured pairs to a consumer over a valid/ready handshake.
- Maintains a sticky OR of all captured flags and a saturating count of results dropped while full, so ALU output is never silently lost.

Parameters:
- DATA_W, 10, width of the ALU result word (signed, stored as raw bits).
- FLAG_W, 4, width of the ALU flag vector.
- DEPTH, 4, number of entries; must be a power of two, >= 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid  in  1  ALU result valid this cycle.
- i_result  in  DATA_W  ALU result word.
- i_flag  in  FLAG_W  ALU flag vector.
- o_ready  out  1  FIFO can accept; equals !o_full.
- o_valid  out  1  head entry available; equals !o_empty.
- o_result  out  DATA_W  head entry result.
- o_flag  out  FLAG_W  head entry flags.
- i_ready  in  1  consumer accepts head this cycle.
- o_count  out  ADDR_W+1  occupancy, 0..DEPTH.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.
- o_sticky_flag  out  FLAG_W  OR of flags of all accepted entries since reset/clear.
- i_sticky_clr  in  1  clear sticky flags.
- o_drop_cnt  out  8  saturating count of rejected pushes.
- o_peak  out  ADDR_W+1  high-water mark of o_count (optional feature).

Behaviour:
- Reset (i_rst high at edge): pointers, o_count, o_sticky_flag, o_drop_cnt, o_peak all 0. Memory contents are don't-care. o_valid=0, o_ready=1, o_result=0, o_flag=0. Reset overrides every other input in the same cycle, including mid-operation.
- Push: i_valid && o_ready at the edge. Writes {i_result,i_flag} at the write pointer; the write pointer increments modulo DEPTH (natural wrap).
- Pop: o_valid && i_ready at the edge. The read pointer increments modulo DEPTH.
- Show-ahead: o_result/o_flag are driven from the head entry whenever o_valid=1, and forced to 0 when empty.
  - Latency: an entry pushed at edge N is visible with o_valid=1 after edge N.
  - o_valid/o_result must not change while the consumer stalls (i_ready=0).
- Simultaneous push and pop (0 < count < DEPTH): both occur, count unchanged, FIFO order preserved.
  - Empty: pop impossible; push only.
  - Full: o_ready=0, so no push; the pop proceeds.
- Drop: i_valid && !o_ready at the edge.
  - Data is discarded.
  - o_drop_cnt increments, saturating at 255 (no wrap).
  - The sticky flags are NOT updated for a dropped entry.
- Sticky flags:
  - On a push, o_sticky_flag |= i_flag.
  - i_sticky_clr alone sets it to 0.
  - i_sticky_clr together with a push in the same cycle sets it to i_flag of that push (clear first, then OR).
- o_count, o_full, o_empty and o_ready are derived from registered state only; there is no combinational path from i_valid/i_ready.
- The block performs no arithmetic on data and does no sign handling.

Optional Feature:
- Macro: ALU_FIFO_PEAK_EN.
- When defined:
  - o_peak is a register updated each edge to max(o_peak, next o_count).
  - It is cleared by reset and by i_sticky_clr. On a clear, it is set to the next o_count, not 0.
- When undefined: o_peak is tied to 0 and no register is synthesized.

Test Plan:
- Reset, then push 80, 48, 0, 80 with flags 0 and i_ready=0 -> o_count=4, o_full=1, o_ready=0, o_valid=1, o_result=80.
- From full, push 511 (i_valid=1, i_ready=0) -> o_drop_cnt=1, count stays 4. Then hold i_ready=1 for 4 cycles -> o_result sequence 80, 48, 0, 80, then o_empty=1 and o_result=0. Value 511 never appears.
- At count 2 (entries 16, -16), push 64 and pop in the same cycle -> count stays 2, next head -16, then 64.
- Push with flags 4'b0001, then 4'b1000 -> o_sticky_flag=4'b1001. Assert i_sticky_clr with a push of flags 4'b0100 -> o_sticky_flag=4'b0100.
- Hold full with i_valid=1 for 300 cycles -> o_drop_cnt saturates at 255.
- At count 3 with sticky 4'b0011, assert i_rst for one edge -> o_count=0, o_valid=0, o_sticky_flag=0, o_drop_cnt=0, o_peak=0. With ALU_FIFO_PEAK_EN, before reset o_peak=3.
